// File: rtl/legv8_uart_pkg.sv
// Shared types and constants for the UART blocks beside the LEGv8 core.
// Provides the dump FSM state type, the serialiser state type, the byte
// type and the default baud divisor (50 MHz / 115200).
package legv8_uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    SEND,
    NEXT,
    FINISH
  } dump_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-low
//   data_in   in   byte to send, taken when valid_in && ready_out
//   valid_in  in   byte offered
//   ready_out out  high when idle and in the last cycle of a stop bit, so a
//                  new frame can follow with no gap
//   tx_out    out  serial line, idle high
module uart_tx_byte
  import legv8_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  uart_byte_t data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] STOP_IDX = 4'd9;

  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [8:0]        frame_q, frame_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    tx_d      = tx_q;
    bit_end   = (baud_q == BAUD_LAST);
    ready_out = (state_q == TX_IDLE) || (bit_end && (bit_q == STOP_IDX));

    if (valid_in && ready_out) begin
      // Start bit goes out now; data bits then the stop bit shift out of frame.
      state_d = TX_BUSY;
      baud_d  = '0;
      bit_d   = '0;
      frame_d = {1'b1, data_in};
      tx_d    = 1'b0;
    end else if (state_q == TX_BUSY) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == STOP_IDX) begin
          state_d = TX_IDLE;
          tx_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = frame_q[0];
          frame_d = {1'b1, frame_q[8:1]};
        end
      end else begin
        baud_d = baud_q + BAUD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      frame_q <= '1;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_out = tx_q;

endmodule

// File: rtl/imem_dump_uart_tx.sv
// Instruction-memory dump over UART: reads word_count words starting at
// base_addr (address wraps modulo the imem depth) and sends each as four
// 8N1 bytes, least-significant byte first.
// Ports:
//   clk, rst        clock (rising edge); asynchronous active-low reset
//   start_in        1-cycle pulse starting a dump; ignored while busy or done
//   base_addr_in    first word address, sampled on an accepted start
//   word_count_in   words to send (0..2**ADDR_WIDTH), sampled on accepted start
//   mem_rd_en_out   imem read strobe, one cycle per word
//   mem_addr_out    imem read address, valid with mem_rd_en_out
//   mem_data_in     imem read data, valid the cycle after mem_rd_en_out
//   tx_out          UART line, idle high
//   busy_out        high from the cycle after start until done_out
//   done_out        1-cycle completion pulse
module imem_dump_uart_tx
  import legv8_uart_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [ADDR_WIDTH:0]   word_count_in,
  output logic                  mem_rd_en_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  tx_out,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam logic [2:0] BYTES_PER_WORD = 3'd4;

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   word_idx_q, word_idx_d;
  logic [2:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic                  tx_valid;
  uart_byte_t            tx_data;
  logic                  tx_ready;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    word_idx_d    = word_idx_q;
    byte_cnt_d    = byte_cnt_q;
    word_d        = word_q;
    tx_valid      = 1'b0;
    tx_data       = word_q[7:0];
    mem_rd_en_out = 1'b0;
    mem_addr_out  = '0;

    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          base_d     = base_addr_in;
          count_d    = word_count_in;
          word_idx_d = '0;
          state_d    = (word_count_in == '0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ: begin
        mem_rd_en_out = 1'b1;
        mem_addr_out  = base_q + word_idx_q[ADDR_WIDTH-1:0];
        state_d       = RD_WAIT;
      end
      RD_WAIT: begin
        // Byte 0 is handed to the serialiser straight from the read data
        // while the word is captured, so the start bit appears on the first
        // SEND cycle. The serialiser is always idle here: the previous
        // word's last stop bit ended before NEXT.
        tx_valid   = 1'b1;
        tx_data    = mem_data_in[7:0];
        word_d     = mem_data_in >> 8;
        byte_cnt_d = 3'd1;
        state_d    = SEND;
      end
      SEND: begin
        if (byte_cnt_q != BYTES_PER_WORD) begin
          tx_valid = 1'b1;
          if (tx_ready) begin
            word_d     = word_q >> 8;
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end else if (tx_ready) begin
          // Last byte is in its final stop-bit cycle.
          state_d = NEXT;
        end
      end
      NEXT: begin
        word_idx_d = word_idx_q + (ADDR_WIDTH + 1)'(1);
        state_d    = (word_idx_d == count_q) ? FINISH : RD_REQ;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  assign busy_out = (state_q != IDLE) && (state_q != FINISH);
  assign done_out = (state_q == FINISH);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .data_in  (tx_data),
    .valid_in (tx_valid),
    .ready_out(tx_ready),
    .tx_out   (tx_out)
  );

endmodule

// File: tb/tb_imem_dump_uart_tx.sv
module tb_imem_dump_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;          // 40 cycles per byte
  localparam int WORD_STEP = 3 * FRAME + FRAME + 3;  // 163 cycles start-to-start

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_in = 1'b0;
  logic [5:0]  base_addr_in = '0;
  logic [6:0]  word_count_in = '0;
  logic        mem_rd_en_out;
  logic [5:0]  mem_addr_out;
  logic [31:0] mem_data_in = '0;
  logic        tx_out;
  logic        busy_out;
  logic        done_out;

  imem_dump_uart_tx #(
    .ADDR_WIDTH  (6),
    .DATA_WIDTH  (32),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst_n),
    .start_in     (start_in),
    .base_addr_in (base_addr_in),
    .word_count_in(word_count_in),
    .mem_rd_en_out(mem_rd_en_out),
    .mem_addr_out (mem_addr_out),
    .mem_data_in  (mem_data_in),
    .tx_out       (tx_out),
    .busy_out     (busy_out),
    .done_out     (done_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 64x32 memory, 1-cycle read latency; junk on cycles with no read.
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_rd_en_out) mem_data_in <= mem[mem_addr_out];
    else               mem_data_in <= 32'h0BAD_F00D;
  end

  int n_cmp = 0;
  int n_err = 0;
  int frame_err = 0;
  int rd_q[$];
  int rx_q[$];
  int rx_t[$];

  always @(negedge clk) begin
    if (rst_n && mem_rd_en_out) rd_q.push_back(int'(mem_addr_out));
  end

  // UART receiver: every bit must hold for exactly CPB samples.
  initial begin : rx_mon
    logic [9:0] bits;
    int st;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst_n && tx_out == 1'b0) begin
        st = cyc;
        ab = 1'b0;
        bits = '0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (!rst_n) ab = 1'b1;
            if (!ab) begin
              if (k == 0) bits[b] = tx_out;
              else if (tx_out != bits[b]) frame_err++;
            end
          end
        end
        if (!ab) begin
          if (bits[0] != 1'b0 || bits[9] != 1'b1) frame_err++;
          rx_q.push_back(int'(bits[8:1]));
          rx_t.push_back(st);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    rd_q.delete();
    rx_q.delete();
    rx_t.delete();
    frame_err = 0;
  endtask

  // One full dump with timing, address, byte and framing checks.
  // glitch: pulse start_in (different base/count) mid-dump, which must be ignored.
  task automatic run_dump(input int b, input int c, input int exp_done, input bit glitch);
    int ts;
    int dc;
    int exp_addr;
    int exp_byte;
    clear_logs();
    @(negedge clk);
    base_addr_in  = 6'(b);
    word_count_in = 7'(c);
    start_in      = 1'b1;
    ts = cyc;
    dc = -1;
    for (int i = 0; i < 3000 && dc < 0; i++) begin
      @(negedge clk);
      start_in = 1'b0;
      if (glitch && cyc == ts + 50) begin
        base_addr_in  = 6'd0;
        word_count_in = 7'd5;
        start_in      = 1'b1;
      end
      if (cyc == ts + 1) chk("busy_after_start", int'(busy_out), (c != 0) ? 1 : 0);
      if (done_out) begin
        dc = cyc;
        chk("busy_at_done", int'(busy_out), 0);
      end
    end
    start_in = 1'b0;
    chk("done_cycle", (dc < 0) ? -1 : dc - ts, exp_done);
    repeat (2) @(negedge clk);
    chk("done_pulse_width", int'(done_out), 0);
    chk("rd_count", rd_q.size(), c);
    for (int w = 0; w < c && w < rd_q.size(); w++)
      chk("rd_addr", rd_q[w], (b + w) & 63);
    chk("byte_count", rx_q.size(), 4 * c);
    for (int i = 0; i < rx_q.size() && i < 4 * c; i++) begin
      exp_addr = (b + i / 4) & 63;
      exp_byte = int'((mem[exp_addr] >> (8 * (i % 4))) & 32'hFF);
      chk("byte_value", rx_q[i], exp_byte);
      chk("byte_start", rx_t[i] - ts, 3 + (i / 4) * WORD_STEP + (i % 4) * FRAME);
    end
    chk("frame_errors", frame_err, 0);
  endtask

  typedef struct {
    int base;
    int count;
    int exp_done;   // cycles from start_in to done_out
  } vec_t;

  vec_t vecs[5];
  int bad;

  initial begin
    vecs[0] = '{base: 5,  count: 1, exp_done: 164};
    vecs[1] = '{base: 62, count: 4, exp_done: 653};
    vecs[2] = '{base: 0,  count: 0, exp_done: 1};
    vecs[3] = '{base: 63, count: 2, exp_done: 327};
    vecs[4] = '{base: 10, count: 3, exp_done: 490};

    for (int i = 0; i < 64; i++)
      mem[i] = {8'(i), 8'(i) ^ 8'hA5, ~8'(i), 8'(i) + 8'h3C};
    mem[5] = 32'hDEADBEEF;

    // Reset state
    #12;
    chk("rst_tx", int'(tx_out), 1);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_done", int'(done_out), 0);
    chk("rst_rd_en", int'(mem_rd_en_out), 0);
    chk("rst_addr", int'(mem_addr_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for 100 cycles
    clear_logs();
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy_out !== 1'b0 || done_out !== 1'b0) bad++;
    end
    chk("idle_lines", bad, 0);
    chk("idle_reads", rd_q.size(), 0);

    // Table-driven dumps
    for (int v = 0; v < 5; v++)
      run_dump(vecs[v].base, vecs[v].count, vecs[v].exp_done, 1'b0);

    // start_in during a dump is ignored
    run_dump(20, 2, 327, 1'b1);

    // start_in coinciding with done_out is ignored
    clear_logs();
    @(negedge clk);
    base_addr_in = 6'd0; word_count_in = 7'd0; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    chk("cnt0_done", int'(done_out), 1);
    base_addr_in = 6'd9; word_count_in = 7'd1; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    bad = 0;
    repeat (10) begin
      if (busy_out !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("start_at_done_busy", bad, 0);
    chk("start_at_done_reads", rd_q.size(), 0);

    // start_in on the cycle after done_out is accepted
    @(negedge clk);
    base_addr_in = 6'd0; word_count_in = 7'd0; start_in = 1'b1;
    @(negedge clk);
    chk("first_done", int'(done_out), 1);
    start_in = 1'b0;
    @(negedge clk);
    base_addr_in = 6'd3; word_count_in = 7'd0; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    chk("start_after_done", int'(done_out), 1);

    // Asynchronous reset in the middle of a byte
    clear_logs();
    @(negedge clk);
    base_addr_in = 6'd20; word_count_in = 7'd2; start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", int'(tx_out), 1);
    chk("midrst_busy", int'(busy_out), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("after_rst_tx", int'(tx_out), 1);
    run_dump(40, 1, 164, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
